// File: rtl/display_scan.sv
// Multiplexed 4-digit 7-segment scanner with double-buffered value and leading-zero blanking.
// Outputs are registered from next-state values so the pins never see combinational paths from inputs.
module display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  code,
  output logic        sel,
  output logic [3:0]  an,
  output logic        frame_done
);

  // state | meaning
  // S_GAP | anodes off at start of slot (cnt < GAP), guards against ghosting
  // S_ON  | selected digit driven (cnt >= GAP) unless blanked
  typedef enum logic {S_GAP, S_ON} slot_t;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);

  slot_t         state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   active, active_nx;
  logic [15:0]   shadow, shadow_nx;
  logic          pending, pending_nx;
  logic [3:0]    code_nx, an_nx;
  logic          sel_nx;
  logic          boundary;
  logic [3:0]    nib;
  logic          lz_zero;

  assign boundary   = (idx == 2'd3) && (cnt == LAST);
  assign frame_done = boundary;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (GAP > 0) ? S_GAP : S_ON;
      cnt     <= '0;
      idx     <= 2'd0;
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      code    <= 4'h0;
      sel     <= 1'b1;
      an      <= 4'b1111;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      active  <= active_nx;
      shadow  <= shadow_nx;
      pending <= pending_nx;
      code    <= code_nx;
      sel     <= sel_nx;
      an      <= an_nx;
    end
  end

  always_comb begin
    cnt_nx     = (cnt == LAST) ? '0 : cnt + CW'(1);
    idx_nx     = (cnt == LAST) ? idx + 2'd1 : idx;
    active_nx  = active;
    shadow_nx  = shadow;
    pending_nx = pending;
    state_nx   = state;

    case (state)
      S_GAP:   if (cnt_nx >= GAP_C) state_nx = S_ON;
      S_ON:    if ((cnt == LAST) && (GAP_C != '0)) state_nx = S_GAP;
      default: state_nx = S_GAP;
    endcase

    // Active only changes at the frame boundary, so a frame never mixes old and new digits.
    if (boundary) begin
      if (load) begin
        active_nx  = value;
        shadow_nx  = value;
        pending_nx = 1'b0;
      end else if (pending) begin
        active_nx  = shadow;
        pending_nx = 1'b0;
      end
    end else if (load) begin
      shadow_nx  = value;
      pending_nx = 1'b1;
    end

    case (idx_nx)
      2'd0:    begin nib = active_nx[3:0];   lz_zero = 1'b0; end
      2'd1:    begin nib = active_nx[7:4];   lz_zero = (active_nx[15:4] == 12'h000); end
      2'd2:    begin nib = active_nx[11:8];  lz_zero = (active_nx[15:8] == 8'h00); end
      default: begin nib = active_nx[15:12]; lz_zero = (active_nx[15:12] == 4'h0); end
    endcase

    an_nx   = 4'b1111;
    sel_nx  = 1'b1;
    code_nx = 4'h0;
    if ((state_nx == S_ON) && !(blank_lz && lz_zero)) begin
      an_nx   = ~(4'b0001 << idx_nx);
      sel_nx  = 1'b0;
      code_nx = nib;
    end
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per digit slot (legal range: at least 2).
REQ-002 SHALL have parameter GAP, default 16, meaning the anode-off cycles at the start of each slot (legal range: 0 to REFRESH_DIV-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port load, input, 1 bit: a 1-cycle strobe that captures value.
REQ-006 SHALL have port value, input, 16 bits: four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking; sampled every cycle.
REQ-008 SHALL have port code, output, 4 bits: nibble for the shared 7-segment decoder's switches input.
REQ-009 SHALL have port sel, output, 1 bit: decoder blank control; 1 = all segments off.
REQ-010 SHALL have port an, output, 4 bits: active-low digit enables; an[i] drives digit i.
REQ-011 SHALL have port frame_done, output, 1 bit: a 1-cycle pulse at the end of each 4-digit frame.

Function
REQ-012 SHALL hold two registers: a 16-bit active (displayed) register and a 16-bit shadow register with a pending flag.
REQ-013 SHALL maintain a slot counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..3); cnt increments every cycle.
- When cnt=REFRESH_DIV-1: cnt goes to 0 and idx goes to idx+1 modulo 4.
REQ-014 SHALL run a 2-state slot machine:
- GAP while cnt<GAP.
- ON while cnt>=GAP.
- GAP=0 means every slot is entirely ON.
REQ-015 SHALL, in GAP: drive an=4'b1111, sel=1, code=0.
REQ-016 SHALL, in ON with digit idx not blanked: drive an with only bit idx low, sel=0, and code = active nibble idx.
REQ-017 SHALL, in ON with digit idx blanked: drive an=4'b1111, sel=1, code=0.
REQ-018 SHALL blank digit i (i=3..1) when blank_lz=1 and active nibbles i..3 are all zero.
- Digit 0 is never blanked.
REQ-019 SHALL pass nibbles above 9 to code unchanged, with no blanking; the decoder shows its catch-all pattern.
REQ-020 SHALL derive code, sel, an and frame_done from registered state only, with no combinational path from load or value.
REQ-021 SHALL define the frame boundary as the cycle where idx=3 and cnt=REFRESH_DIV-1.
- frame_done=1 in exactly that cycle and 0 in all others.
REQ-022 SHALL, on load=1 away from the boundary: shadow <= value and pending <= 1.
- A later load before the boundary overwrites shadow (last wins).
REQ-023 SHALL, at the boundary edge with pending=1 and load=0: active <= shadow and pending <= 0.
- The active register changes only at frame boundaries (no tearing).
REQ-024 SHALL, on load=1 in the boundary cycle: active <= value directly and pending <= 0, discarding any older shadow contents.
REQ-025 SHALL leave active unchanged across the boundary when pending=0 and load=0.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, regardless of state, set:
- active=0, shadow=0, pending=0
- cnt=0, idx=0
- an=4'b1111, sel=1, code=0, frame_done=0
REQ-027 SHALL, on the first edge with rst_n=1, resume counting from cnt=0, idx=0, with a load in that cycle accepted normally.

Verification (REFRESH_DIV=8, GAP=2; frame = 32 cycles)
REQ-028 SHALL be verified by a reset test:
- Stimulus: rst_n=0 for 3 cycles.
- Response: an=1111, sel=1, code=0, frame_done=0; after release, first frame_done at cycle 31.
REQ-029 SHALL be verified by a normal scan test:
- Stimulus: load 16'h1234 with blank_lz=0.
- Response, next frame: slot 0 cycles 0-1 have an=1111, sel=1; cycles 2-7 have an=1110, code=4, sel=0.
- Response, slot 3: an=0111, code=1.
- Response: frame_done every 32 cycles.
REQ-030 SHALL be verified by a leading-zero test:
- Stimulus: value 16'h0050 with blank_lz=1.
- Response: slots 3 and 2 give an=1111, sel=1; slot 1 gives code=5; slot 0 gives code=0.
- Stimulus: value 16'h0000. Response: only slot 0 lit, with code=0.
REQ-031 SHALL be verified by a double-load test:
- Stimulus: load 16'h1111, then 16'h2222, mid-frame.
- Response: the current frame keeps its old digits; the next frame shows 2222; pending clears.
REQ-032 SHALL be verified by a boundary-load test:
- Stimulus: load 16'h9876 in the frame_done cycle, with an older value pending.
- Response: the next frame shows 9876.
REQ-033 SHALL be verified by a mid-slot reset test:
- Stimulus: rst_n=0 for 1 cycle at idx=2, cnt=5.
- Response: reset values on that edge; afterwards the scan restarts at digit 0 and displays 0 in every digit.
